// File: rtl/lcd_message_scheduler_if.sv
// Requester and LCD-driver signals shared with lcd_message_scheduler.
// The scheduler uses the slave modport; the master modport is the requesters plus driver side.
interface lcd_message_scheduler_if #(
    parameter int MSG_CHARS = 16
);
    logic                   req0;
    logic [8*MSG_CHARS-1:0] msg0;
    logic                   ack0;
    logic                   req1;
    logic [8*MSG_CHARS-1:0] msg1;
    logic                   ack1;
    logic                   lcd_ready;
    logic [7:0]             lcd_char;
    logic                   lcd_write_char;
    logic                   lcd_home;
    logic                   busy;
    logic                   done;
    logic                   done_id;

    modport master (
        output req0, msg0, req1, msg1, lcd_ready,
        input  ack0, ack1, lcd_char, lcd_write_char, lcd_home, busy, done, done_id
    );

    modport slave (
        input  req0, msg0, req1, msg1, lcd_ready,
        output ack0, ack1, lcd_char, lcd_write_char, lcd_home, busy, done, done_id
    );
endinterface

// File: rtl/lcd_message_scheduler.sv
// Round-robin arbiter between two 16-char message sources feeding one LCD driver:
// captures the granted message, then issues home followed by one writeChar per character.
module lcd_message_scheduler #(
    parameter int MSG_CHARS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lcd_message_scheduler_if.slave  bus
);
    localparam int W  = 8 * MSG_CHARS;
    localparam int IW = $clog2(MSG_CHARS + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(MSG_CHARS);

    typedef enum logic [2:0] {IDLE, HOME, HOME_WAIT, CHAR, CHAR_WAIT, DONE} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    shift_reg, shift_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic            last_reg, last_next;
    logic            grant_reg, grant_next;
    logic            seen_low_reg, seen_low_next;
    logic            ack0_reg, ack0_next;
    logic            ack1_reg, ack1_next;
    logic            home_reg, home_next;
    logic            write_reg, write_next;
    logic [7:0]      char_reg, char_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            done_id_reg, done_id_next;
    logic            pick;
    logic [7:0]      head_char;

    // Non-printable bytes go out as a space.
    function automatic logic [7:0] printable(input logic [7:0] b);
        return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
    endfunction

    assign head_char = printable(shift_reg[W-1 -: 8]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            idx_reg      <= '0;
            last_reg     <= 1'b1;
            grant_reg    <= 1'b0;
            seen_low_reg <= 1'b0;
            ack0_reg     <= 1'b0;
            ack1_reg     <= 1'b0;
            home_reg     <= 1'b0;
            write_reg    <= 1'b0;
            char_reg     <= 8'h20;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            done_id_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            idx_reg      <= idx_next;
            last_reg     <= last_next;
            grant_reg    <= grant_next;
            seen_low_reg <= seen_low_next;
            ack0_reg     <= ack0_next;
            ack1_reg     <= ack1_next;
            home_reg     <= home_next;
            write_reg    <= write_next;
            char_reg     <= char_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            done_id_reg  <= done_id_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        idx_next      = idx_reg;
        last_next     = last_reg;
        grant_next    = grant_reg;
        seen_low_next = seen_low_reg;
        ack0_next     = 1'b0;
        ack1_next     = 1'b0;
        home_next     = 1'b0;
        write_next    = 1'b0;
        char_next     = char_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        done_id_next  = done_id_reg;
        pick          = (bus.req0 && bus.req1) ? ~last_reg : bus.req1;

        case (state_reg)
            IDLE: begin
                if (bus.lcd_ready && (bus.req0 || bus.req1)) begin
                    grant_next = pick;
                    last_next  = pick;
                    shift_next = pick ? bus.msg1 : bus.msg0;
                    ack0_next  = ~pick;
                    ack1_next  = pick;
                    busy_next  = 1'b1;
                    home_next  = 1'b1;
                    idx_next   = '0;
                    state_next = HOME;
                end
            end
            HOME: begin
                seen_low_next = 1'b0;
                state_next    = HOME_WAIT;
            end
            HOME_WAIT, CHAR_WAIT: begin
                // Wait for ready to fall before trusting a high level; the driver lags a cycle.
                if (!seen_low_reg) begin
                    if (!bus.lcd_ready)
                        seen_low_next = 1'b1;
                end else if (bus.lcd_ready) begin
                    if (state_reg == CHAR_WAIT && idx_reg == IDX_LAST) begin
                        done_next    = 1'b1;
                        done_id_next = grant_reg;
                        busy_next    = 1'b0;
                        state_next   = DONE;
                    end else begin
                        write_next = 1'b1;
                        char_next  = head_char;
                        shift_next = shift_reg << 8;
                        idx_next   = idx_reg + IW'(1);
                        state_next = CHAR;
                    end
                end
            end
            CHAR: begin
                seen_low_next = 1'b0;
                state_next    = CHAR_WAIT;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ack0           = ack0_reg;
    assign bus.ack1           = ack1_reg;
    assign bus.lcd_home       = home_reg;
    assign bus.lcd_write_char = write_reg;
    assign bus.lcd_char       = char_reg;
    assign bus.busy           = busy_reg;
    assign bus.done           = done_reg;
    assign bus.done_id        = done_id_reg;
endmodule
